// File: rtl/req_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : req_arbiter8
// Purpose  : Eight-way request arbiter sharing one downstream resource.
//            Picks at most one requester per arbitration (fixed priority or
//            round-robin), then holds a registered one-hot grant until the
//            grantee completes, withdraws, is disabled, or hits the hold limit.
// Ports    : clk          rising-edge clock
//            rst_n        asynchronous active-low reset
//            en_n_i       active-low enable; 1 forces release, blocks grants
//            req_n_i[7:0] active-low requests
//            rr_mode_i    1 = round-robin, 0 = fixed priority (index 0 first)
//            done_i       grantee completion strobe
//            gnt_o[7:0]   registered one-hot grant
//            gnt_id_o     registered grantee index (0 when idle)
//            gnt_valid_o  registered grant-held flag
//            timeout_o    registered one-cycle hold-limit revoke pulse
//            gs_n_o       combinational group select (0 = enabled request)
// Revision : 1.0 - initial release
// ============================================================================
module req_arbiter8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_n_i,
    input  logic [7:0] req_n_i,
    input  logic       rr_mode_i,
    input  logic       done_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_id_o,
    output logic       gnt_valid_o,
    output logic       timeout_o,
    output logic       gs_n_o
);

    localparam int              c_CW    = $clog2(HOLD_MAX + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(HOLD_MAX - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q;
    logic [7:0]      gnt_q;
    logic [2:0]      gnt_id_q;
    logic            gnt_valid_q;
    logic            timeout_q;
    logic [2:0]      ptr_q;
    logic [c_CW-1:0] cnt_q;

    logic [7:0] w_req;
    logic       w_any;
    logic [2:0] w_fix_id;
    logic       w_fix_found;
    logic [2:0] w_rr_id;
    logic       w_rr_found;
    logic [2:0] w_win;
    logic       w_grantee_gone;
    logic       w_release;

    assign w_req  = ~req_n_i;
    assign w_any  = |w_req;
    assign gs_n_o = ~(~en_n_i & w_any);

    // Fixed priority: lowest asserted index.
    always_comb begin
        w_fix_id    = 3'd0;
        w_fix_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!w_fix_found && w_req[i]) begin
                w_fix_id    = 3'(i);
                w_fix_found = 1'b1;
            end
        end
    end

    // Round-robin: search ptr+1 .. ptr+8; the 3-bit sum wraps modulo 8,
    // and k=8 revisits the previous winner last.
    always_comb begin
        w_rr_id    = 3'd0;
        w_rr_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!w_rr_found && w_req[ptr_q + 3'(k)]) begin
                w_rr_id    = ptr_q + 3'(k);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_win          = rr_mode_i ? w_rr_id : w_fix_id;
    assign w_grantee_gone = req_n_i[gnt_id_q];
    assign w_release      = en_n_i | done_i | w_grantee_gone | (cnt_q == c_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= 3'd7;
            cnt_q       <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!en_n_i && w_any) begin
                        state_q     <= S_GRANT;
                        gnt_q       <= 8'(1) << w_win;
                        gnt_id_q    <= w_win;
                        gnt_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        ptr_q       <= w_win;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        state_q     <= S_IDLE;
                        gnt_q       <= 8'h00;
                        gnt_id_q    <= 3'd0;
                        gnt_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        // Only a pure hold-limit revoke is flagged.
                        timeout_q   <= ~en_n_i & ~done_i & ~w_grantee_gone;
                    end else begin
                        cnt_q <= cnt_q + c_CW'(1);
                    end
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_req_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_arbiter8
// Purpose  : Self-checking bench for req_arbiter8 (HOLD_MAX = 4) using a
//            behavioural cycle model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_arbiter8;

    localparam int c_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       en_n;
    logic [7:0] req_n;
    logic       rr_mode;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic       gs_n;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_valid;
    int m_id;
    int m_cnt;
    int m_ptr;
    bit m_to;

    req_arbiter8 #(.HOLD_MAX(c_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_n_i      (en_n),
        .req_n_i     (req_n),
        .rr_mode_i   (rr_mode),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid),
        .timeout_o   (timeout),
        .gs_n_o      (gs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_cnt = 0; m_ptr = 7; m_to = 0;
    endtask

    function automatic int pick();
        if (rr_mode) begin
            for (int k = 1; k <= 8; k++)
                if (req_n[(m_ptr + k) % 8] == 1'b0) return (m_ptr + k) % 8;
        end else begin
            for (int i = 0; i < 8; i++)
                if (req_n[i] == 1'b0) return i;
        end
        return 0;
    endfunction

    // Applies the arbitration rules for one rising edge using current inputs.
    task automatic model_step();
        m_to = 0;
        if (!m_valid) begin
            if (!en_n && req_n != 8'hFF) begin
                m_id = pick(); m_ptr = m_id; m_valid = 1; m_cnt = 0;
            end
        end else if (en_n || done || req_n[m_id]) begin
            m_valid = 0; m_id = 0; m_cnt = 0;
        end else if (m_cnt == c_HOLD - 1) begin
            m_valid = 0; m_id = 0; m_cnt = 0; m_to = 1;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic logic [13:0] exp_vec();
        logic [7:0] g;
        logic       s;
        g = m_valid ? (8'(1) << m_id) : 8'h00;
        s = (!en_n && req_n != 8'hFF) ? 1'b0 : 1'b1;
        return {g, 3'(m_id), m_valid, m_to, s};
    endfunction

    // Advance one clock edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_idle();
        req_n = 8'hFF; done = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_n = 1'b1; req_n = 8'hFF; rr_mode = 1'b0; done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, gnt_id, gnt_valid, timeout, gs_n} !== {8'h00, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got %h required %h",
                     {gnt, gnt_id, gnt_valid, timeout, gs_n}, {8'h00, 3'd0, 1'b0, 1'b0, 1'b1});
        end
        rst_n = 1'b1;
        en_n  = 1'b0;
        tick();
    endtask

    task automatic test_rr_rotation();
        rr_mode = 1'b1; req_n = 8'h00;
        for (int n = 0; n < 9; n++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_id !== 3'(n % 8) || gnt !== (8'(1) << (n % 8))) begin
                failures++;
                $display("FAIL rr_rotation[%0d]: got id=%0d gnt=%h v=%b required id=%0d",
                         n, gnt_id, gnt, gnt_valid, n % 8);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL rr_gap[%0d]: got gnt=%h v=%b to=%b required gnt=00 v=0 to=0",
                         n, gnt, gnt_valid, timeout);
            end
        end
        go_idle();
    endtask

    task automatic test_fixed();
        logic [7:0] exp_g [0:2];
        exp_g[0] = 8'h04; exp_g[1] = 8'h00; exp_g[2] = 8'h04;
        rr_mode = 1'b0; req_n = 8'b1110_1011;
        for (int n = 0; n < 3; n++) begin
            done = (n == 1);
            if (n == 1) done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== exp_g[n] || gnt_id !== (n == 1 ? 3'd0 : 3'd2)) begin
                failures++;
                $display("FAIL fixed_grant[%0d]: got gnt=%h id=%0d required gnt=%h",
                         n, gnt, gnt_id, exp_g[n]);
            end
            if (n == 0) done = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_hold_limit();
        rr_mode = 1'b0; req_n = 8'hDF;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if (n < 4 && (gnt !== 8'h20 || timeout !== 1'b0)) begin
                failures++;
                $display("FAIL hold_active[%0d]: got gnt=%h to=%b required gnt=20 to=0", n, gnt, timeout);
            end else if (n == 4 && (gnt !== 8'h00 || timeout !== 1'b1)) begin
                failures++;
                $display("FAIL hold_timeout: got gnt=%h to=%b required gnt=00 to=1", gnt, timeout);
            end else if (n == 5 && (gnt !== 8'h20 || timeout !== 1'b0)) begin
                failures++;
                $display("FAIL hold_regrant: got gnt=%h to=%b required gnt=20 to=0", gnt, timeout);
            end
        end
        go_idle();
    endtask

    task automatic test_simultaneous();
        rr_mode = 1'b0; req_n = 8'hF7;
        tick();
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_at_limit: got gnt=%h v=%b to=%b required gnt=00 v=0 to=0",
                     gnt, gnt_valid, timeout);
        end
        tick();
        tick();
        req_n = 8'hFF;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_release: got gnt=%h v=%b to=%b required gnt=00 v=0 to=0",
                     gnt, gnt_valid, timeout);
        end
        go_idle();
    endtask

    task automatic test_enable();
        rr_mode = 1'b0; req_n = 8'h7F;
        tick();
        en_n = 1'b1;
        #1;
        checks++;
        if (gs_n !== 1'b1) begin
            failures++;
            $display("FAIL gs_n_disabled: got %b required 1", gs_n);
        end
        tick();
        checks++;
        if (gnt !== 8'h00 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL enable_release: got gnt=%h to=%b required gnt=00 to=0", gnt, timeout);
        end
        repeat (3) tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL enable_block: got gnt=%h v=%b required gnt=00 v=0", gnt, gnt_valid);
        end
        en_n = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'h80 || gs_n !== 1'b0) begin
            failures++;
            $display("FAIL enable_resume: got gnt=%h gs_n=%b required gnt=80 gs_n=0", gnt, gs_n);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_grant();
        rr_mode = 1'b0; req_n = 8'hFB;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, gnt_id, gnt_valid, timeout} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset: got gnt=%h id=%0d v=%b to=%b required all 0",
                     gnt, gnt_id, gnt_valid, timeout);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        rr_mode = 1'b1; req_n = 8'h00;
        tick();
        checks++;
        if (gnt_id !== 3'd0 || gnt !== 8'h01 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL rr_after_reset: got id=%0d gnt=%h required id=0 gnt=01", gnt_id, gnt);
        end
        go_idle();
    endtask

    task automatic test_wrap();
        // Fixed grant to 6 loads ptr=6; rr with requests at 2 and 7 picks 7.
        rr_mode = 1'b0; req_n = 8'hBF;
        tick();
        go_idle();
        rr_mode = 1'b1; req_n = 8'h7B;
        tick();
        checks++;
        if (gnt_id !== 3'd7 || gnt !== 8'h80) begin
            failures++;
            $display("FAIL rr_wrap: got id=%0d gnt=%h required id=7 gnt=80", gnt_id, gnt);
        end
        go_idle();
    endtask

    task automatic test_random();
        logic [13:0] exp;
        for (int n = 0; n < 400; n++) begin
            en_n    = ($urandom_range(0, 15) == 0);
            rr_mode = $urandom_range(0, 1);
            done    = ($urandom_range(0, 5) == 0);
            req_n   = ($urandom_range(0, 3) == 0) ? 8'($urandom) | 8'($urandom) : 8'($urandom);
            #1;
            exp = exp_vec();
            checks++;
            if (gs_n !== exp[0]) begin
                failures++;
                $display("FAIL rand_gs_n[%0d]: got %b required %b", n, gs_n, exp[0]);
            end
            tick();
            exp = exp_vec();
            checks++;
            if ({gnt, gnt_id, gnt_valid, timeout, gs_n} !== exp) begin
                failures++;
                $display("FAIL rand_cycle[%0d]: got gnt=%h id=%0d v=%b to=%b gs=%b required %h",
                         n, gnt, gnt_id, gnt_valid, timeout, gs_n, exp);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_rr_rotation();
        test_fixed();
        test_hold_limit();
        test_simultaneous();
        test_enable();
        test_reset_mid_grant();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
